unidade_controle_mc: RTL

Multi-cycle control unit for the RV64 subset datapath (PC, IR, register bank, ULA, data memory, Mux1–Mux4).
- Consumes the decoded fields from IR (opcode, funct3, funct7 bit) and the ULA branch flag.
- Produces every write enable, mux select and the 4-bit ULA operation code, sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It is the producing end of the control interface the datapath consumes.

---
 rtl/unidade_controle_mc_pkg.sv | 38 +++
 rtl/unidade_controle_mc_if.sv | 31 +++
 rtl/unidade_controle_mc_alu_control.sv | 29 ++
 rtl/unidade_controle_mc.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/unidade_controle_mc_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, ULA codes,
// FSM state encoding and the PC / write-back mux selects.
package uc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_ALU = 2'b10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

endpackage

// File: rtl/unidade_controle_mc_if.sv
// Control interface between the control unit (master) and the datapath (slave).
interface unidade_controle_mc_if;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7;
  logic       alu_flag;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       rf_we;
  logic       mem_we;
  logic       alu_src;
  logic       alu_a_sel;
  logic [1:0] wb_sel;
  logic [3:0] alu_ctrl;
  logic       instr_done;
  logic [2:0] state_dbg;

  modport master (
    input  run, opcode, funct3, funct7, alu_flag,
    output ir_we, pc_we, pc_src, rf_we, mem_we, alu_src, alu_a_sel,
           wb_sel, alu_ctrl, instr_done, state_dbg
  );

  modport slave (
    output run, opcode, funct3, funct7, alu_flag,
    input  ir_we, pc_we, pc_src, rf_we, mem_we, alu_src, alu_a_sel,
           wb_sel, alu_ctrl, instr_done, state_dbg
  );
endinterface

// File: rtl/unidade_controle_mc_alu_control.sv
// Combinational ULA operation decode from the IR fields.
module alu_control
  import uc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          // funct7 selects sub only for register-register; addi has no sub form
          3'b000:  alu_ctrl = (opcode == OP_R && funct7) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b010:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OP_BRANCH: alu_ctrl = ALU_SUB;
      default:   alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/unidade_controle_mc.sv
// Multi-cycle control unit sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Build option UC_ILLEGAL_TRAP_EN: unlisted opcodes trap into a sticky HALT instead of a NOP.
//
// state  | meaning
// FETCH  | idle while run=0; otherwise count MEM_LAT cycles, load IR on the last
// DECODE | register bank registered read
// EXEC   | ULA operation; branches and NOPs retire here
// MEM    | count MEM_LAT cycles of data access; stores retire on the last
// WB     | register write-back and PC update
// HALT   | illegal-opcode trap, left only by reset
module unidade_controle_mc
  import uc_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  unidade_controle_mc_if.master cif
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cnt_last;
  logic       sel_a, sel_b;
  logic [3:0] alu_ctrl_raw;

  alu_control u_alu_control (
    .opcode   (cif.opcode),
    .funct3   (cif.funct3),
    .funct7   (cif.funct7),
    .alu_ctrl (alu_ctrl_raw)
  );

  assign cnt_last      = (cnt_q == LAST_CNT);
  assign cif.alu_ctrl  = reset ? ALU_ADD : alu_ctrl_raw;
  assign cif.state_dbg = state_q;

  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    case (cif.opcode)
      OP_R, OP_BRANCH:            begin sel_a = 1'b1; sel_b = 1'b1; end
      OP_I, OP_LOAD, OP_STORE,
      OP_JALR:                    sel_a = 1'b1;
      default:                    ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cif.ir_we      = 1'b0;
    cif.pc_we      = 1'b0;
    cif.pc_src     = PC_SRC_PC4;
    cif.rf_we      = 1'b0;
    cif.mem_we     = 1'b0;
    cif.alu_src    = 1'b0;
    cif.alu_a_sel  = 1'b0;
    cif.wb_sel     = WB_MEM;
    cif.instr_done = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (cif.run) begin
          if (cnt_last) begin
            cif.ir_we = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_DECODE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        cif.alu_a_sel = sel_a;
        cif.alu_src   = sel_b;
        case (cif.opcode)
          OP_R, OP_I, OP_JAL, OP_JALR, OP_AUIPC: state_d = ST_WB;
          OP_LOAD, OP_STORE:                     state_d = ST_MEM;
          OP_BRANCH: begin
            cif.pc_we      = 1'b1;
            cif.pc_src     = cif.alu_flag ? PC_SRC_IMM : PC_SRC_PC4;
            cif.instr_done = 1'b1;
            state_d        = ST_FETCH;
          end
          default: begin
`ifdef UC_ILLEGAL_TRAP_EN
            state_d = ST_HALT;
`else
            cif.pc_we      = 1'b1;
            cif.instr_done = 1'b1;
            state_d        = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEM: begin
        cif.alu_a_sel = sel_a;
        cif.alu_src   = sel_b;
        if (cnt_last) begin
          cnt_d = 4'd0;
          if (cif.opcode == OP_STORE) begin
            cif.mem_we     = 1'b1;
            cif.pc_we      = 1'b1;
            cif.instr_done = 1'b1;
            state_d        = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WB: begin
        cif.alu_a_sel  = sel_a;
        cif.alu_src    = sel_b;
        cif.rf_we      = 1'b1;
        cif.pc_we      = 1'b1;
        cif.instr_done = 1'b1;
        state_d        = ST_FETCH;
        case (cif.opcode)
          OP_LOAD: cif.wb_sel = WB_MEM;
          OP_JAL:  begin cif.wb_sel = WB_PC4; cif.pc_src = PC_SRC_IMM; end
          OP_JALR: begin cif.wb_sel = WB_PC4; cif.pc_src = PC_SRC_ALU; end
          default: cif.wb_sel = WB_ALU;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    // Strobes are suppressed while reset is sampled so an aborted access never commits.
    if (reset) begin
      cif.ir_we      = 1'b0;
      cif.pc_we      = 1'b0;
      cif.pc_src     = PC_SRC_PC4;
      cif.rf_we      = 1'b0;
      cif.mem_we     = 1'b0;
      cif.alu_src    = 1'b0;
      cif.alu_a_sel  = 1'b0;
      cif.wb_sel     = WB_MEM;
      cif.instr_done = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
